// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial adder sequencer with start/busy/done handshake
//
// Purpose: computes a+b one bit per cycle using a single shared full_adder,
// LSB first. The result is WIDTH bits wide plus a carry out. Both are
// registered and held until the next operation completes.
//
// Optional feature macro: SERIAL_ADDER_SUB_EN. When it is defined, a `sub`
// input is added and the block computes a-b. The default build is add only.
//
// Ports:
//   clk    in   1      system clock, rising edge
//   reset  in   1      synchronous active-high reset
//   start  in   1      request, sampled only in IDLE
//   sub    in   1      subtract select, sampled with start (SERIAL_ADDER_SUB_EN only)
//   a      in   WIDTH  operand A, captured on accepted start
//   b      in   WIDTH  operand B, captured on accepted start
//   busy   out  1      high while the operation is in RUN
//   done   out  1      one-cycle pulse, result valid
//   sum    out  WIDTH  registered result
//   c_out  out  1      registered carry out of the MSB

module full_adder (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = x ^ y ^ cin;
  assign cout = (x & y) | (cin & (x ^ y));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh, res_next, b_load;
  logic [CNT_W-1:0] cnt;
  logic             carry, carry_init;
  logic             fa_s, fa_c;
  logic             last_bit;

  full_adder u_fa (
    .x    (a_sh[0]),
    .y    (b_sh[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_c)
  );

  // Subtraction is a + ~b + 1: invert B on capture and seed the carry with 1.
`ifdef SERIAL_ADDER_SUB_EN
  assign b_load     = sub ? ~b : b;
  assign carry_init = sub;
`else
  assign b_load     = b;
  assign carry_init = 1'b0;
`endif

  assign last_bit = (cnt == LAST);
  // The new sum bit enters at the MSB. After WIDTH shifts, bit 0 holds the LSB.
  assign res_next = {fa_s, res_sh[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (start) state_next = RUN;
      RUN: begin
        busy = 1'b1;
        if (last_bit) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      c_out  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh   <= a;
            b_sh   <= b_load;
            carry  <= carry_init;
            cnt    <= '0;
            res_sh <= '0;
          end
        end
        RUN: begin
          a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
          carry  <= fa_c;
          res_sh <= res_next;
          cnt    <= cnt + 1'b1;
          if (last_bit) begin
            sum   <= res_next;
            c_out <= fa_c;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - self-checking bench for serial_adder_ctrl
module tb_serial_adder_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset, start, sub;
  logic [W-1:0] a, b;
  logic         busy, done, c_out;
  logic [W-1:0] sum;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic [W-1:0] es;
    logic         ec;
  } vec_t;

  vec_t tbl[7];

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub),
`endif
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .c_out (c_out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: plain (W+1)-bit arithmetic. Subtraction is a + (2^W-1-b) + 1.
  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    logic [W:0] r;
    if (s) r = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
    else   r = {1'b0, x} + {1'b0, y};
    return r;
  endfunction

  task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic s, input logic [W-1:0] es, input logic ec);
    int lat, busy_n;
    logic [W-1:0] prev_sum;
    logic prev_c, held;
    prev_sum = sum;
    prev_c   = c_out;
    held     = 1'b1;
    a = x; b = y; sub = s; start = 1'b1;
    tick;
    start = 1'b0;
    a = ~x; b = ~y;
    lat = 0; busy_n = 0;
    while (!done && lat < 40) begin
      lat++;
      if (busy) busy_n++;
      if (sum !== prev_sum || c_out !== prev_c) held = 1'b0;
      tick;
    end
    check({tag, " latency"}, 32'(lat), 32'(W));
    check({tag, " busy_cycles"}, 32'(busy_n), 32'(W));
    check({tag, " held_during_run"}, 32'(held), 32'd1);
    check({tag, " busy_at_done"}, 32'(busy), 32'd0);
    check({tag, " sum"}, 32'(sum), 32'(es));
    check({tag, " c_out"}, 32'(c_out), 32'(ec));
    tick;
    check({tag, " done_one_cycle"}, 32'(done), 32'd0);
    tick;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic stable;
    logic [W:0] exp;
    int n_done;
    int done_at[2];
    logic [W-1:0] done_sum[2];
    logic [W-1:0] rx, ry;
    logic rs;

    tbl[0] = '{8'h3C, 8'h5A, 1'b0, 8'h96, 1'b0};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    tbl[2] = '{8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1};
    tbl[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    tbl[4] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
    tbl[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    tbl[6] = '{8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0};

    reset = 1'b1; start = 1'b0; a = '0; b = '0; sub = 1'b0;
    repeat (3) tick;
    reset = 1'b0;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset sum", 32'(sum), 32'd0);
    check("reset c_out", 32'(c_out), 32'd0);
    stable = 1'b1;
    a = 8'h55; b = 8'hAA;
    repeat (20) begin
      tick;
      if (busy !== 1'b0 || done !== 1'b0 || sum !== '0 || c_out !== 1'b0) stable = 1'b0;
    end
    check("idle stable 20 cycles", 32'(stable), 32'd1);

    for (int i = 0; i < 7; i++)
      run_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].es, tbl[i].ec);

    // Hold start high. Operand changes in flight must not matter.
    a = 8'h10; b = 8'h20; sub = 1'b0; start = 1'b1;
    n_done = 0;
    for (int c = 1; c <= 40 && n_done < 2; c++) begin
      tick;
      if (c == 3) a = 8'h77;
      if (done) begin
        done_at[n_done]  = c;
        done_sum[n_done] = sum;
        n_done++;
      end
    end
    start = 1'b0;
    check("hold dones", 32'(n_done), 32'd2);
    if (n_done == 2) begin
      check("hold first done cycle", 32'(done_at[0]), 32'(W + 1));
      check("hold period", 32'(done_at[1] - done_at[0]), 32'(W + 2));
      check("hold first sum", 32'(done_sum[0]), 32'h30);
      check("hold second sum", 32'(done_sum[1]), 32'h97);
    end
    tick; tick;
    check("hold back to idle", 32'(busy), 32'd0);

    // Reset in the fourth RUN cycle discards the operation.
    a = 8'h12; b = 8'h34; start = 1'b1;
    tick;
    start = 1'b0;
    repeat (3) tick;
    check("midrun busy before reset", 32'(busy), 32'd1);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check("midrun busy", 32'(busy), 32'd0);
    check("midrun done", 32'(done), 32'd0);
    check("midrun sum", 32'(sum), 32'd0);
    check("midrun c_out", 32'(c_out), 32'd0);
    stable = 1'b1;
    repeat (12) begin
      tick;
      if (done !== 1'b0 || busy !== 1'b0) stable = 1'b0;
    end
    check("midrun no done", 32'(stable), 32'd1);
    run_op("after_reset", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0);

    // Reset wins over start on the same edge.
    a = 8'h01; b = 8'h01; start = 1'b1; reset = 1'b1;
    tick;
    reset = 1'b0; start = 1'b0;
    check("reset over start busy", 32'(busy), 32'd0);
    tick;
    check("reset over start still idle", 32'(busy), 32'd0);

`ifdef SERIAL_ADDER_SUB_EN
    run_op("sub1", 8'h10, 8'h03, 1'b1, 8'h0D, 1'b1);
    run_op("sub2", 8'h03, 8'h10, 1'b1, 8'hF3, 1'b0);
    run_op("sub0", 8'h3C, 8'h5A, 1'b0, 8'h96, 1'b0);
`endif

    for (int i = 0; i < 25; i++) begin
      rx = W'($urandom);
      ry = W'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
      rs = 1'($urandom_range(0, 1));
`else
      rs = 1'b0;
`endif
      exp = model(rx, ry, rs);
      run_op($sformatf("rand%0d", i), rx, ry, rs, exp[W-1:0], exp[W]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
